// File: rtl/frog_collision_arbiter.sv
// Per-pixel object arbiter and per-frame frog collision detector.
// object_to_draw is combinational; the collision and drown reports are registered, one cycle after each frame boundary.
module frog_collision_arbiter #(
  parameter int N            = 3,
  parameter int DROWN_FRAMES = 2
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic         startOfFrame,
  input  logic         frog_draw_req,
  input  logic         log_draw_req,
  input  logic         waterfall_draw_req,
  input  logic         endbank_draw_req,
  output logic [N-1:0] object_to_draw,
  output logic         col_frog_log,
  output logic         col_frog_water,
  output logic         col_frog_endbank,
  output logic         frog_drown
);

  localparam logic [N-1:0] CODE_BACKGROUND = N'(0);
  localparam logic [N-1:0] CODE_WATERFALL  = N'(1);
  localparam logic [N-1:0] CODE_LOG        = N'(2);
  localparam logic [N-1:0] CODE_FROG       = N'(3);
  localparam logic [N-1:0] CODE_ENDBANK    = N'(4);
  localparam logic [3:0]   DROWN_LIMIT     = 4'(DROWN_FRAMES);

  typedef enum logic {
    UNARMED,
    RUN
  } state_t;

  state_t     state;
  logic       acc_fl;
  logic       acc_fw;
  logic       acc_fe;
  logic [3:0] dcnt;

  logic hit_fl;
  logic hit_fw;
  logic hit_fe;
  logic drown_cond;

  // Zero-latency arbitration keeps the code aligned with the RGB streams entering the mux.
  always_comb begin
    object_to_draw = CODE_BACKGROUND;
    if (frog_draw_req)
      object_to_draw = CODE_FROG;
    else if (log_draw_req)
      object_to_draw = CODE_LOG;
    else if (waterfall_draw_req)
      object_to_draw = CODE_WATERFALL;
    else if (endbank_draw_req)
      object_to_draw = CODE_ENDBANK;
  end

  assign hit_fl     = frog_draw_req & log_draw_req;
  assign hit_fw     = frog_draw_req & waterfall_draw_req;
  assign hit_fe     = frog_draw_req & endbank_draw_req;
  assign drown_cond = acc_fw & ~acc_fl;

  // The boundary pixel belongs to the new frame, so accumulators load rather than OR on startOfFrame.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state            <= UNARMED;
      acc_fl           <= 1'b0;
      acc_fw           <= 1'b0;
      acc_fe           <= 1'b0;
      dcnt             <= 4'd0;
      col_frog_log     <= 1'b0;
      col_frog_water   <= 1'b0;
      col_frog_endbank <= 1'b0;
      frog_drown       <= 1'b0;
    end else begin
      col_frog_log     <= 1'b0;
      col_frog_water   <= 1'b0;
      col_frog_endbank <= 1'b0;
      frog_drown       <= 1'b0;
      if (startOfFrame) begin
        acc_fl <= hit_fl;
        acc_fw <= hit_fw;
        acc_fe <= hit_fe;
        state  <= RUN;
        if (state == RUN) begin
          col_frog_log     <= acc_fl;
          col_frog_water   <= acc_fw;
          col_frog_endbank <= acc_fe;
          // Saturating count; the pulse fires only on the step that reaches the limit.
          if (drown_cond) begin
            if (dcnt < DROWN_LIMIT) begin
              dcnt       <= dcnt + 4'd1;
              frog_drown <= ((dcnt + 4'd1) == DROWN_LIMIT);
            end
          end else begin
            dcnt <= 4'd0;
          end
        end
      end else begin
        acc_fl <= acc_fl | hit_fl;
        acc_fw <= acc_fw | hit_fw;
        acc_fe <= acc_fe | hit_fe;
      end
    end
  end

endmodule

// File: tb/tb_frog_collision_arbiter.sv
// Directed bench for frog_collision_arbiter: priority, per-frame reports, drowning, reset and boundary cases.
module tb_frog_collision_arbiter;

  logic       CLK;
  logic       RESETn;
  logic       startOfFrame;
  logic       frog_draw_req;
  logic       log_draw_req;
  logic       waterfall_draw_req;
  logic       endbank_draw_req;
  logic [2:0] object_to_draw;
  logic       col_frog_log;
  logic       col_frog_water;
  logic       col_frog_endbank;
  logic       frog_drown;

  int n_compared   = 0;
  int n_mismatched = 0;

  frog_collision_arbiter #(
    .N            (3),
    .DROWN_FRAMES (2)
  ) dut (
    .CLK                (CLK),
    .RESETn             (RESETn),
    .startOfFrame       (startOfFrame),
    .frog_draw_req      (frog_draw_req),
    .log_draw_req       (log_draw_req),
    .waterfall_draw_req (waterfall_draw_req),
    .endbank_draw_req   (endbank_draw_req),
    .object_to_draw     (object_to_draw),
    .col_frog_log       (col_frog_log),
    .col_frog_water     (col_frog_water),
    .col_frog_endbank   (col_frog_endbank),
    .frog_drown         (frog_drown)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one pixel, let the clock sample it, and return 1 ns after the edge.
  task automatic apply_stimulus(input logic sof, input logic frog, input logic lg,
                                input logic water, input logic endb);
    startOfFrame       = sof;
    frog_draw_req      = frog;
    log_draw_req       = lg;
    waterfall_draw_req = water;
    endbank_draw_req   = endb;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected report bits packed as {log, water, endbank, drown}.
  task automatic check_reports(input string tag, input logic [3:0] exp);
    check_output(tag, {4'b0, col_frog_log, col_frog_water, col_frog_endbank, frog_drown}, {4'b0, exp});
  endtask

  task automatic check_dcnt(input string tag, input logic [3:0] exp);
    check_output(tag, {4'b0, dut.dcnt}, {4'b0, exp});
  endtask

  // A frame of n pixels of the given overlap, two idle pixels, then the closing boundary.
  task automatic frame(input int n, input logic lg, input logic water, input logic endb);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b1, lg, water, endb);
    idle(2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RESETn             = 1'b0;
    startOfFrame       = 1'b0;
    frog_draw_req      = 1'b0;
    log_draw_req       = 1'b0;
    waterfall_draw_req = 1'b0;
    endbank_draw_req   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reports("reset_reports", 4'b0000);
    check_output("reset_obj", {5'b0, object_to_draw}, 8'd0);
    check_dcnt("reset_dcnt", 4'd0);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // Combinational priority, all within one clock period so nothing is sampled.
    frog_draw_req = 1'b1; log_draw_req = 1'b1; waterfall_draw_req = 1'b1; endbank_draw_req = 1'b1;
    #1 check_output("prio_frog", {5'b0, object_to_draw}, 8'd3);
    frog_draw_req = 1'b0;
    #1 check_output("prio_log", {5'b0, object_to_draw}, 8'd2);
    log_draw_req = 1'b0;
    #1 check_output("prio_water", {5'b0, object_to_draw}, 8'd1);
    waterfall_draw_req = 1'b0;
    #1 check_output("prio_endbank", {5'b0, object_to_draw}, 8'd4);
    endbank_draw_req = 1'b0;
    #1 check_output("prio_background", {5'b0, object_to_draw}, 8'd0);

    // Log collision: first boundary arms only, second one reports.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("first_sof_silent", 4'b0000);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_reports("midframe_silent", 4'b0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("log_pulse", 4'b1000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("log_pulse_one_cycle", 4'b0000);

    // Boundary pixel belongs to the new frame.
    idle(3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_reports("boundary_prev_frame", 4'b0000);
    idle(3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("boundary_this_frame", 4'b0100);
    check_dcnt("boundary_dcnt", 4'd1);

    // Empty frame clears the drown counter and reports nothing.
    idle(3);
    check_reports("empty_mid", 4'b0000);
    idle(3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("empty_report", 4'b0000);
    check_dcnt("empty_dcnt", 4'd0);

    // Drowning with DROWN_FRAMES = 2.
    frame(3, 1'b0, 1'b1, 1'b0);
    check_reports("drown_f1", 4'b0100);
    check_dcnt("drown_f1_dcnt", 4'd1);
    frame(3, 1'b0, 1'b1, 1'b0);
    check_reports("drown_f2", 4'b0101);
    check_dcnt("drown_f2_dcnt", 4'd2);
    idle(1);
    check_reports("drown_f2_one_cycle", 4'b0000);
    frame(3, 1'b0, 1'b1, 1'b0);
    check_reports("drown_f3_saturated", 4'b0100);
    check_dcnt("drown_f3_dcnt", 4'd2);
    frame(3, 1'b1, 1'b0, 1'b0);
    check_reports("drown_f4_log", 4'b1000);
    check_dcnt("drown_f4_dcnt", 4'd0);
    frame(2, 1'b0, 1'b1, 1'b0);
    check_reports("drown_f5", 4'b0100);
    frame(2, 1'b0, 1'b1, 1'b0);
    check_reports("drown_f6", 4'b0101);

    // Endbank, and log plus water together (log rescues the frog).
    frame(2, 1'b0, 1'b0, 1'b1);
    check_reports("endbank_pulse", 4'b0010);
    check_dcnt("endbank_dcnt", 4'd0);
    frame(2, 1'b1, 1'b1, 1'b0);
    check_reports("log_and_water", 4'b1100);
    check_dcnt("log_and_water_dcnt", 4'd0);

    // Back-to-back boundaries: the second report reflects only the single boundary pixel.
    idle(2);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_reports("b2b_first", 4'b0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("b2b_second", 4'b0010);

    // Reset mid-frame, asserted while a report pulse is visible.
    frame(2, 1'b0, 1'b1, 1'b0);
    check_reports("pre_reset_pulse", 4'b0100);
    check_dcnt("pre_reset_dcnt", 4'd1);
    frog_draw_req = 1'b1; log_draw_req = 1'b1; waterfall_draw_req = 1'b1; endbank_draw_req = 1'b1;
    RESETn = 1'b0;
    #1;
    check_reports("reset_async_reports", 4'b0000);
    check_dcnt("reset_async_dcnt", 4'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reports("post_reset_first_sof", 4'b0000);
    frame(2, 1'b1, 1'b0, 1'b0);
    check_reports("post_reset_second_sof", 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/frog_collision_arbiter.md
# frog_collision_arbiter

Per-pixel object arbiter and per-frame collision detector feeding the VGA objects multiplexer. Each pixel clock it turns the individual object draw requests into the `object_to_draw` code the mux consumes. It also accumulates object overlaps over each frame and reports frog/log, frog/water, frog/endbank and drowning events to the game-control logic once per frame, at the frame boundary.

## Interface
Parameters:
- N, 3, width of `object_to_draw`; must match the mux.
- DROWN_FRAMES, 2, consecutive "frog on water, not on log" frames required before `frog_drown` fires; legal range 1..15.

Ports:
- CLK  input  1  pixel clock.
- RESETn  input  1  asynchronous, active-low reset.
- startOfFrame  input  1  single-cycle pulse on the first pixel of each frame.
- frog_draw_req  input  1  frog sprite covers the current pixel.
- log_draw_req  input  1  a log covers the current pixel.
- waterfall_draw_req  input  1  water/waterfall covers the current pixel.
- endbank_draw_req  input  1  end bank covers the current pixel.
- object_to_draw  output  N  object code for the current pixel: BACKGROUND=0, WATERFALL=1, LOG=2, FROG=3, ENDBANK=4.
- col_frog_log  output  1  one-cycle pulse: frog overlapped a log in the previous frame.
- col_frog_water  output  1  one-cycle pulse: frog overlapped water in the previous frame.
- col_frog_endbank  output  1  one-cycle pulse: frog overlapped the end bank in the previous frame.
- frog_drown  output  1  one-cycle pulse: drowning condition met for DROWN_FRAMES consecutive frames.

## Operation
- Arbitration is combinational, with zero latency, so it stays aligned with the RGB streams entering the mux.
  - Priority order: FROG > LOG > WATERFALL > ENDBANK > BACKGROUND.
  - The ENDBANK code (4) intentionally falls to the mux default path.
- Per-frame accumulators are sticky registers `acc_fl`, `acc_fw` and `acc_fe`:
  - `acc_fl` sets on any pixel with frog & log.
  - `acc_fw` sets on frog & waterfall.
  - `acc_fe` sets on frog & endbank.
  - Requests are sampled regardless of arbitration outcome.
- State machine, 2 states:
  - UNARMED (reset state). Accumulates, but emits no report pulses. The first startOfFrame transitions to RUN and reloads the accumulators.
  - RUN. On each startOfFrame:
    - Register the report pulses from the current accumulator values.
    - Update the drown counter.
    - Reload each accumulator with that same cycle's overlap term: the boundary pixel belongs to the new frame, so it loads rather than ORs.
- Drown counter `dcnt` is 4 bits, saturating at DROWN_FRAMES. Evaluated per frame in RUN:
  - If `acc_fw & ~acc_fl`, increment.
  - Otherwise clear to 0.
  - `frog_drown` pulses in the report cycle where `dcnt` reaches DROWN_FRAMES from below. It does not repeat while saturated.
  - The counter clears only when the condition fails, which re-arms the pulse.
- Frames with no frog pixels produce no pulses and clear `dcnt`.

## Timing
- `object_to_draw` has the same-cycle combinational path; it is the only non-registered output.
- Report pulses are high for exactly one cycle: the cycle immediately after the startOfFrame edge. They are never high on consecutive cycles unless startOfFrame pulses back to back. In that case the second report reflects the single boundary pixel.
- Reset values (asynchronous assert, synchronous use after deassert):
  - all pulses 0;
  - accumulators 0;
  - `dcnt` 0;
  - state UNARMED.
- Reset mid-frame discards the partial frame. No pulse is emitted until the second startOfFrame after release.
- startOfFrame held high for multiple cycles is illegal. Behaviour is defined anyway: each high cycle is treated as a boundary.
- All requests are assumed synchronous to CLK; the block does no synchronisation.

## Test plan
- Priority: drive all four requests high, then drop them one at a time. Require `object_to_draw` = 3, 2, 1, 4, 0 on the same cycle as each change.
- Log collision: after reset, issue startOfFrame, then 5 pixels with frog & log, then startOfFrame. Require `col_frog_log` = 1 for exactly one cycle after the second pulse, with the other three report outputs 0.
- Boundary pixel: frog & water asserted only on the startOfFrame cycle of frame k. Require no `col_frog_water` at the end of frame k-1, and `col_frog_water` = 1 at the end of frame k.
- Drowning (DROWN_FRAMES=2):
  - Frames 1 and 2: frog & water, no log. Require `frog_drown` pulse at the end of frame 2 only.
  - Frame 3: same condition. Require no pulse.
  - Frame 4: frog & log. Require `dcnt` to clear and no pulse.
  - Frames 5 and 6: water-only. Require a pulse at the end of frame 6.
- Reset mid-frame: overlaps present, assert RESETn low for 3 cycles mid-frame. Require all outputs 0 immediately, and no pulse at the first startOfFrame after release.
- Empty frame: no frog for a full frame. Require all four report outputs to stay 0 and `dcnt` = 0.
